// File: rtl/qspi_xfer_seq.sv
// Quad-SPI transfer sequencer: chip select, CMD/ADDR/DUMMY/DATA phases and a
// mode-0 SCLK made from a programmable half-period tick.
module qspi_xfer_seq (
    input  logic        h_clk,
    input  logic        h_rstn,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [23:0] addr,
    input  logic        addr_quad,
    input  logic [3:0]  dummy_cyc,
    input  logic [7:0]  data_len,
    input  logic        data_wr,
    input  logic [7:0]  clk_div,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        sclk_out,
    output logic        cs_n_out,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    input  logic [3:0]  io_in
);

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_HOLD, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic [3:0]  oe_q, oe_d;
    logic [31:0] sh_q, sh_d;
    logic        quad_q, quad_d;
    logic [4:0]  cyc_q, cyc_d;
    logic [7:0]  bytes_q, bytes_d;
    logic [23:0] addr_q, addr_d;
    logic        aquad_q, aquad_d;
    logic [3:0]  dummy_q, dummy_d;
    logic [7:0]  len_q, len_d;
    logic        wr_q, wr_d;
    logic [7:0]  div_cfg_q, div_cfg_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        have_q, have_d;
    logic [3:0]  rx_hi_q, rx_hi_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;

    logic stall;
    logic tick;
    logic enter_post;

    // A write byte boundary with nothing to send freezes SCLK low until the
    // holding register fills; the divider restarts from zero afterwards.
    assign stall    = (state_q == S_DATA) && wr_q && !have_q;
    assign tick     = (div_q == div_cfg_q) && !stall;
    assign tx_ready = (state_q == S_DATA) && wr_q && !hold_full_q;

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign sclk_out = sclk_q;
    assign cs_n_out = cs_n_q;
    assign io_oe    = oe_q;
    assign io_out   = quad_q ? sh_q[31:28] : {3'b000, sh_q[31]};
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

    always_ff @(posedge h_clk or negedge h_rstn) begin
        if (!h_rstn) begin
            state_q     <= S_IDLE;
            div_q       <= 8'd0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            oe_q        <= 4'b0000;
            sh_q        <= 32'd0;
            quad_q      <= 1'b0;
            cyc_q       <= 5'd0;
            bytes_q     <= 8'd0;
            addr_q      <= 24'd0;
            aquad_q     <= 1'b0;
            dummy_q     <= 4'd0;
            len_q       <= 8'd0;
            wr_q        <= 1'b0;
            div_cfg_q   <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            have_q      <= 1'b0;
            rx_hi_q     <= 4'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            oe_q        <= oe_d;
            sh_q        <= sh_d;
            quad_q      <= quad_d;
            cyc_q       <= cyc_d;
            bytes_q     <= bytes_d;
            addr_q      <= addr_d;
            aquad_q     <= aquad_d;
            dummy_q     <= dummy_d;
            len_q       <= len_d;
            wr_q        <= wr_d;
            div_cfg_q   <= div_cfg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            have_q      <= have_d;
            rx_hi_q     <= rx_hi_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        oe_d        = oe_q;
        sh_d        = sh_q;
        quad_d      = quad_q;
        cyc_d       = cyc_q;
        bytes_d     = bytes_q;
        addr_d      = addr_q;
        aquad_d     = aquad_q;
        dummy_d     = dummy_q;
        len_d       = len_q;
        wr_d        = wr_q;
        div_cfg_d   = div_cfg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        have_d      = have_q;
        rx_hi_d     = rx_hi_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        enter_post  = 1'b0;

        if ((state_q == S_IDLE) || stall || tick) begin
            div_d = 8'd0;
        end else begin
            div_d = div_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = addr;
                    aquad_d     = addr_quad;
                    dummy_d     = dummy_cyc;
                    len_d       = data_len;
                    wr_d        = data_wr;
                    div_cfg_d   = clk_div;
                    sh_d        = {cmd, 24'd0};
                    quad_d      = 1'b0;
                    oe_d        = 4'b0001;
                    cs_n_d      = 1'b0;
                    cyc_d       = 5'd8;
                    have_d      = 1'b0;
                    hold_full_d = 1'b0;
                    state_d     = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                if (tick) begin
                    state_d = S_CMD;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (stall) begin
                    if (hold_full_q) begin
                        sh_d        = {hold_q, 24'd0};
                        have_d      = 1'b1;
                        hold_full_d = 1'b0;
                    end
                end else if (tick && !sclk_q) begin
                    sclk_d = 1'b1;
                    if ((state_q == S_DATA) && !wr_q) begin
                        if (cyc_q == 5'd2) begin
                            rx_hi_d = io_in;
                        end else begin
                            rx_data_d  = {rx_hi_q, io_in};
                            rx_valid_d = 1'b1;
                        end
                    end
                end else if (tick) begin
                    sclk_d = 1'b0;
                    if (cyc_q != 5'd1) begin
                        cyc_d = cyc_q - 5'd1;
                        sh_d  = quad_q ? {sh_q[27:0], 4'h0} : {sh_q[30:0], 1'b0};
                    end else begin
                        // Last falling edge of the phase: set up the next one now
                        // so its first bits are on the lines before the next rise.
                        case (state_q)
                            S_CMD: begin
                                sh_d    = {addr_q, 8'd0};
                                quad_d  = aquad_q;
                                cyc_d   = aquad_q ? 5'd6 : 5'd24;
                                oe_d    = aquad_q ? 4'b1111 : 4'b0001;
                                state_d = S_ADDR;
                            end
                            S_ADDR: begin
                                if (dummy_q != 4'd0) begin
                                    cyc_d   = {1'b0, dummy_q};
                                    oe_d    = 4'b0000;
                                    state_d = S_DUMMY;
                                end else begin
                                    enter_post = 1'b1;
                                end
                            end
                            S_DUMMY: begin
                                enter_post = 1'b1;
                            end
                            default: begin
                                bytes_d = bytes_q - 8'd1;
                                if (bytes_q == 8'd1) begin
                                    state_d = S_CS_HOLD;
                                end else begin
                                    cyc_d = 5'd2;
                                    if (wr_q) begin
                                        if (hold_full_q) begin
                                            sh_d        = {hold_q, 24'd0};
                                            hold_full_d = 1'b0;
                                        end else begin
                                            have_d = 1'b0;
                                        end
                                    end
                                end
                            end
                        endcase
                    end
                end
            end
            S_CS_HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    oe_d    = 4'b0000;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_post) begin
            if (len_q != 8'd0) begin
                cyc_d   = 5'd2;
                bytes_d = len_q;
                quad_d  = 1'b1;
                sh_d    = 32'd0;
                have_d  = 1'b0;
                oe_d    = wr_q ? 4'b1111 : 4'b0000;
                state_d = S_DATA;
            end else begin
                state_d = S_CS_HOLD;
            end
        end

        // Holding register is only ever filled while empty and only drained
        // while full, so these two updates never collide.
        if (tx_ready && tx_valid) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_qspi_xfer_seq.sv
// Directed testbench for qspi_xfer_seq with a passive bus monitor and a
// simple quad-read flash data model.
module tb_qspi_xfer_seq;

    logic        h_clk = 1'b0;
    logic        h_rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [23:0] addr = 24'h0;
    logic        addr_quad = 1'b0;
    logic [3:0]  dummy_cyc = 4'h0;
    logic [7:0]  data_len = 8'h00;
    logic        data_wr = 1'b0;
    logic [7:0]  clk_div = 8'h00;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        sclk_out;
    logic        cs_n_out;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [3:0]  io_in = 4'h0;

    int n_cmp = 0;
    int n_fail = 0;

    qspi_xfer_seq dut (
        .h_clk(h_clk), .h_rstn(h_rstn), .start(start), .cmd(cmd), .addr(addr),
        .addr_quad(addr_quad), .dummy_cyc(dummy_cyc), .data_len(data_len),
        .data_wr(data_wr), .clk_div(clk_div), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .done(done), .sclk_out(sclk_out), .cs_n_out(cs_n_out), .io_out(io_out),
        .io_oe(io_oe), .io_in(io_in)
    );

    always #5 h_clk = ~h_clk;

    // Monitor state: cumulative counters, read by the tests as deltas.
    int   cyc_n = 0, rise_n = 0, rx_n = 0, done_n = 0, cs_low_n = 0;
    int   cs_rise_n = 0, txr_n = 0, hi_n = 0, falls = 0;
    logic prev_sclk = 1'b0, prev_cs = 1'b1;
    logic [3:0] cap_io [0:4095];
    logic [3:0] cap_oe [0:4095];
    int         rise_cyc [0:4095];
    logic [7:0] rx_log [0:63];
    int         rx_cyc [0:63];
    int         model_start = 0, model_n = 0;
    logic [3:0] model_nib [0:7];

    always @(negedge h_clk) begin : mon
        int idx;
        cyc_n++;
        if (!prev_sclk && sclk_out) begin
            cap_io[rise_n % 4096]   = io_out;
            cap_oe[rise_n % 4096]   = io_oe;
            rise_cyc[rise_n % 4096] = cyc_n;
            rise_n++;
        end
        if (cs_n_out) falls = 0;
        else if (prev_sclk && !sclk_out) falls++;
        if (sclk_out) hi_n++;
        if (rx_valid) begin
            rx_log[rx_n % 64] = rx_data;
            rx_cyc[rx_n % 64] = cyc_n;
            rx_n++;
        end
        if (done) done_n++;
        if (!cs_n_out) cs_low_n++;
        if (!prev_cs && cs_n_out) cs_rise_n++;
        if (tx_ready) txr_n++;
        prev_sclk = sclk_out;
        prev_cs   = cs_n_out;
        idx = falls - model_start;
        io_in = (idx >= 0 && idx < model_n) ? model_nib[idx] : 4'h0;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [7:0] c, input logic [23:0] a, input logic q,
                               input logic [3:0] d, input logic [7:0] l, input logic w,
                               input logic [7:0] dv);
        @(posedge h_clk); #1;
        cmd = c; addr = a; addr_quad = q; dummy_cyc = d; data_len = l; data_wr = w; clk_div = dv;
        start = 1'b1;
        @(posedge h_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < bound && !seen; k++) begin
            @(negedge h_clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done: got no done pulse in %0d cycles, want one", name, bound);
        end
        repeat (2) @(posedge h_clk);
        #1;
    endtask

    task automatic test_reset();
        h_rstn = 1'b0;
        @(posedge h_clk); #2;
        n_cmp++;
        if ({sclk_out, cs_n_out} !== 2'b01) begin
            n_fail++; $display("FAIL rst_sclk_cs: got %b, want 01", {sclk_out, cs_n_out});
        end
        n_cmp++;
        if ({io_oe, io_out} !== 8'h00) begin
            n_fail++; $display("FAIL rst_io: got %h, want 00", {io_oe, io_out});
        end
        n_cmp++;
        if ({busy, done, tx_ready, rx_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_ctrl: got %b, want 0000", {busy, done, tx_ready, rx_valid});
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_rx_data: got %h, want 00", rx_data);
        end
        @(negedge h_clk);
        h_rstn = 1'b1;
        repeat (2) @(posedge h_clk); #1;
        n_cmp++;
        if ({busy, cs_n_out} !== 2'b01) begin
            n_fail++; $display("FAIL rst_idle: got %b, want 01", {busy, cs_n_out});
        end
    endtask

    task automatic test_single_line();
        int b = rise_n, d0 = done_n, c0 = cs_low_n;
        logic [31:0] got = 32'h0;
        model_n = 0;
        pulse_start(8'h9F, 24'hC3A501, 1'b0, 4'd0, 8'd0, 1'b0, 8'd1);
        wait_done(1000, "single");
        n_cmp++;
        if (rise_n - b !== 32) begin
            n_fail++; $display("FAIL single_sclk_count: got %0d, want 32", rise_n - b);
        end
        for (int i = 0; i < 32; i++) got = {got[30:0], cap_io[(b + i) % 4096][0]};
        n_cmp++;
        if (got !== 32'h9FC3A501) begin
            n_fail++; $display("FAIL single_serial: got %h, want 9fc3a501", got);
        end
        n_cmp++;
        if ({cap_oe[b % 4096], cap_oe[(b + 31) % 4096]} !== 8'h11) begin
            n_fail++; $display("FAIL single_oe: got %h, want 11", {cap_oe[b % 4096], cap_oe[(b + 31) % 4096]});
        end
        n_cmp++;
        if (rise_cyc[(b + 1) % 4096] - rise_cyc[b % 4096] !== 4) begin
            n_fail++; $display("FAIL single_period: got %0d, want 4", rise_cyc[(b + 1) % 4096] - rise_cyc[b % 4096]);
        end
        n_cmp++;
        if (rise_cyc[(b + 8) % 4096] - rise_cyc[(b + 7) % 4096] !== 4) begin
            n_fail++; $display("FAIL single_cmd_addr_gap: got %0d, want 4", rise_cyc[(b + 8) % 4096] - rise_cyc[(b + 7) % 4096]);
        end
        n_cmp++;
        if (done_n - d0 !== 1) begin
            n_fail++; $display("FAIL single_done_count: got %0d, want 1", done_n - d0);
        end
        n_cmp++;
        if (cs_low_n - c0 !== 132) begin
            n_fail++; $display("FAIL single_cs_low: got %0d, want 132", cs_low_n - c0);
        end
    endtask

    task automatic test_quad_read();
        int b = rise_n, r0 = rx_n, t0 = txr_n;
        logic [7:0]  gc = 8'h0;
        logic [23:0] ga = 24'h0;
        model_start = 18; model_n = 4;
        model_nib[0] = 4'hA; model_nib[1] = 4'h5; model_nib[2] = 4'h3; model_nib[3] = 4'hC;
        pulse_start(8'hEB, 24'h123456, 1'b1, 4'd4, 8'd2, 1'b0, 8'd1);
        wait_done(1000, "qread");
        n_cmp++;
        if (rise_n - b !== 22) begin
            n_fail++; $display("FAIL qread_sclk_count: got %0d, want 22", rise_n - b);
        end
        for (int i = 0; i < 8; i++) gc = {gc[6:0], cap_io[(b + i) % 4096][0]};
        for (int i = 0; i < 6; i++) ga = {ga[19:0], cap_io[(b + 8 + i) % 4096]};
        n_cmp++;
        if ({gc, ga} !== 32'hEB123456) begin
            n_fail++; $display("FAIL qread_cmd_addr: got %h, want eb123456", {gc, ga});
        end
        n_cmp++;
        if ({cap_oe[(b + 8) % 4096], cap_oe[(b + 14) % 4096], cap_oe[(b + 18) % 4096]} !== 12'hF00) begin
            n_fail++; $display("FAIL qread_oe: got %h, want f00",
                {cap_oe[(b + 8) % 4096], cap_oe[(b + 14) % 4096], cap_oe[(b + 18) % 4096]});
        end
        n_cmp++;
        if (rx_n - r0 !== 2) begin
            n_fail++; $display("FAIL qread_rx_count: got %0d, want 2", rx_n - r0);
        end
        n_cmp++;
        if ({rx_log[r0 % 64], rx_log[(r0 + 1) % 64]} !== 16'hA53C) begin
            n_fail++; $display("FAIL qread_rx_data: got %h, want a53c", {rx_log[r0 % 64], rx_log[(r0 + 1) % 64]});
        end
        n_cmp++;
        if (rx_cyc[r0 % 64] !== rise_cyc[(b + 19) % 4096]) begin
            n_fail++; $display("FAIL qread_rx_timing: got cycle %0d, want %0d", rx_cyc[r0 % 64], rise_cyc[(b + 19) % 4096]);
        end
        n_cmp++;
        if (txr_n - t0 !== 0) begin
            n_fail++; $display("FAIL qread_tx_ready: got %0d ready cycles, want 0", txr_n - t0);
        end
        model_n = 0;
    endtask

    task automatic test_quad_write();
        int b = rise_n, d0 = done_n, cr0 = cs_rise_n, h0 = hi_n;
        logic [23:0] gd = 24'h0;
        logic [7:0]  bytes [0:2];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        model_n = 0;
        fork
            begin
                pulse_start(8'h32, 24'hA1B2C3, 1'b1, 4'd0, 8'd3, 1'b1, 8'd0);
                wait_done(2000, "qwrite");
            end
            begin
                @(posedge h_clk); #1;
                for (int k = 0; k < 3; k++) begin
                    bit acc = 1'b0;
                    if (k == 2) begin
                        repeat (20) @(posedge h_clk);
                        #1;
                    end
                    tx_data = bytes[k];
                    tx_valid = 1'b1;
                    for (int j = 0; j < 1500 && !acc; j++) begin
                        @(negedge h_clk);
                        acc = tx_ready;
                        @(posedge h_clk);
                    end
                    #1;
                    tx_valid = 1'b0;
                end
            end
        join
        n_cmp++;
        if (rise_n - b !== 20) begin
            n_fail++; $display("FAIL qwrite_sclk_count: got %0d, want 20", rise_n - b);
        end
        for (int i = 0; i < 6; i++) gd = {gd[19:0], cap_io[(b + 14 + i) % 4096]};
        n_cmp++;
        if (gd !== 24'h112233) begin
            n_fail++; $display("FAIL qwrite_nibbles: got %h, want 112233", gd);
        end
        n_cmp++;
        if (cap_oe[(b + 14) % 4096] !== 4'hF) begin
            n_fail++; $display("FAIL qwrite_oe: got %h, want f", cap_oe[(b + 14) % 4096]);
        end
        n_cmp++;
        if (rise_cyc[(b + 18) % 4096] - rise_cyc[(b + 17) % 4096] <= 2) begin
            n_fail++; $display("FAIL qwrite_gap: got %0d cycles, want more than 2",
                rise_cyc[(b + 18) % 4096] - rise_cyc[(b + 17) % 4096]);
        end
        n_cmp++;
        if (hi_n - h0 !== 20) begin
            n_fail++; $display("FAIL qwrite_sclk_high: got %0d high cycles, want 20", hi_n - h0);
        end
        n_cmp++;
        if ({cs_rise_n - cr0, done_n - d0} !== {32'd1, 32'd1}) begin
            n_fail++; $display("FAIL qwrite_cs_done: got cs_rises %0d done %0d, want 1 1", cs_rise_n - cr0, done_n - d0);
        end
    endtask

    task automatic test_back_to_back();
        int b = rise_n, d0 = done_n;
        bit seen = 1'b0;
        logic [7:0] c1 = 8'h0, c2 = 8'h0;
        model_n = 0;
        pulse_start(8'h05, 24'h000000, 1'b1, 4'd0, 8'd0, 1'b0, 8'd0);
        repeat (5) @(posedge h_clk); #1;
        cmd = 8'h06; start = 1'b1;
        @(posedge h_clk); #1;
        start = 1'b0;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge h_clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++; $display("FAIL b2b_first_done: got no done pulse, want one");
        end
        start = 1'b1;
        @(posedge h_clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_start_on_done: got busy %b, want 0", busy);
        end
        @(posedge h_clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_start_after_done: got busy %b, want 1", busy);
        end
        wait_done(500, "b2b");
        n_cmp++;
        if ({rise_n - b, done_n - d0} !== {32'd28, 32'd2}) begin
            n_fail++; $display("FAIL b2b_counts: got rises %0d done %0d, want 28 2", rise_n - b, done_n - d0);
        end
        for (int i = 0; i < 8; i++) begin
            c1 = {c1[6:0], cap_io[(b + i) % 4096][0]};
            c2 = {c2[6:0], cap_io[(b + 14 + i) % 4096][0]};
        end
        n_cmp++;
        if ({c1, c2} !== 16'h0506) begin
            n_fail++; $display("FAIL b2b_cmds: got %h, want 0506", {c1, c2});
        end
    endtask

    task automatic test_reset_mid();
        int b = rise_n, d0;
        bit in_addr = 1'b0;
        logic [31:0] got = 32'h0;
        model_n = 0;
        pulse_start(8'h03, 24'hFFFFFF, 1'b0, 4'd0, 8'd0, 1'b0, 8'd1);
        for (int k = 0; k < 400 && !in_addr; k++) begin
            @(negedge h_clk);
            if (rise_n - b >= 12) in_addr = 1'b1;
        end
        d0 = done_n;
        n_cmp++;
        if (!in_addr || busy !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_reach_addr: got busy %b reached %b, want 1 1", busy, in_addr);
        end
        #3;
        h_rstn = 1'b0;
        #1;
        n_cmp++;
        if ({sclk_out, cs_n_out, io_oe, io_out} !== 10'b01_0000_0000) begin
            n_fail++; $display("FAIL rstmid_bus: got %b, want 0100000000", {sclk_out, cs_n_out, io_oe, io_out});
        end
        n_cmp++;
        if ({busy, done, tx_ready, rx_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b, want 0000", {busy, done, tx_ready, rx_valid});
        end
        repeat (5) @(posedge h_clk);
        @(negedge h_clk);
        h_rstn = 1'b1;
        repeat (3) @(posedge h_clk); #1;
        n_cmp++;
        if (done_n - d0 !== 0) begin
            n_fail++; $display("FAIL rstmid_no_done: got %0d, want 0", done_n - d0);
        end
        b = rise_n;
        pulse_start(8'h9F, 24'h000001, 1'b0, 4'd0, 8'd0, 1'b0, 8'd0);
        wait_done(500, "rstmid_fresh");
        for (int i = 0; i < 32; i++) got = {got[30:0], cap_io[(b + i) % 4096][0]};
        n_cmp++;
        if ({rise_n - b, got} !== {32'd32, 32'h9F000001}) begin
            n_fail++; $display("FAIL rstmid_fresh: got rises %0d word %h, want 32 9f000001", rise_n - b, got);
        end
    endtask

    task automatic test_clk_div_extremes();
        int b, r0;
        b = rise_n; r0 = rx_n;
        model_start = 14; model_n = 2; model_nib[0] = 4'h5; model_nib[1] = 4'hA;
        pulse_start(8'h6B, 24'h000010, 1'b1, 4'd0, 8'd1, 1'b0, 8'd0);
        wait_done(500, "div0");
        n_cmp++;
        if (rise_cyc[(b + 1) % 4096] - rise_cyc[b % 4096] !== 2) begin
            n_fail++; $display("FAIL div0_period: got %0d, want 2", rise_cyc[(b + 1) % 4096] - rise_cyc[b % 4096]);
        end
        n_cmp++;
        if ({rx_n - r0, rise_n - b} !== {32'd1, 32'd16} || rx_log[r0 % 64] !== 8'h5A) begin
            n_fail++; $display("FAIL div0_rx: got count %0d rises %0d byte %h, want 1 16 5a",
                rx_n - r0, rise_n - b, rx_log[r0 % 64]);
        end
        b = rise_n; r0 = rx_n;
        model_nib[0] = 4'hC; model_nib[1] = 4'h7;
        pulse_start(8'h6B, 24'h000010, 1'b1, 4'd0, 8'd1, 1'b0, 8'd255);
        wait_done(12000, "div255");
        n_cmp++;
        if (rise_cyc[(b + 1) % 4096] - rise_cyc[b % 4096] !== 512) begin
            n_fail++; $display("FAIL div255_period: got %0d, want 512", rise_cyc[(b + 1) % 4096] - rise_cyc[b % 4096]);
        end
        n_cmp++;
        if ({rx_n - r0, rise_n - b} !== {32'd1, 32'd16} || rx_log[r0 % 64] !== 8'hC7) begin
            n_fail++; $display("FAIL div255_rx: got count %0d rises %0d byte %h, want 1 16 c7",
                rx_n - r0, rise_n - b, rx_log[r0 % 64]);
        end
        model_n = 0;
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_quad_read();
        test_quad_write();
        test_back_to_back();
        test_reset_mid();
        test_clk_div_extremes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_xfer_seq.md
QSPI_XFER_SEQ -- requirements
Module: qspi_xfer_seq

Interface
REQ-001 SHALL have ports: h_clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: h_rstn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: start in 1 begin transfer; cmd in 8 opcode; addr in 24 flash address; addr_quad in 1 (1 = 4-line address).
REQ-004 SHALL have: dummy_cyc in 4 dummy SCLK cycles; data_len in 8 bytes (0 = no data phase); data_wr in 1 (1 = write, 0 = read); clk_div in 8 divider.
REQ-005 SHALL have: tx_data in 8, tx_valid in 1, tx_ready out 1 write-byte stream.
REQ-006 SHALL have: rx_data out 8, rx_valid out 1 read-byte strobe.
REQ-007 SHALL have: busy out 1; done out 1 one-cycle completion pulse.
REQ-008 SHALL have: sclk_out out 1; cs_n_out out 1; io_out out 4; io_oe out 4; io_in in 4.

Function
REQ-009 SHALL sample all config inputs (cmd, addr, addr_quad, dummy_cyc, data_len, data_wr, clk_div) on start in IDLE; start SHALL be ignored while busy=1.
REQ-010 SHALL implement states IDLE, CS_SETUP, CMD, ADDR, DUMMY, DATA, CS_HOLD, DONE.
REQ-011 Half-period tick: 8-bit counter 0..clk_div, tick when count==clk_div then wrap to 0; counter cleared on leaving IDLE; SCLK freq = h_clk/(2*(clk_div+1)); clk_div=0 gives tick every cycle.
REQ-012 SCLK mode 0: sclk_out low in IDLE/CS_SETUP/CS_HOLD/DONE; in shift phases odd tick = rising edge (sample io_in), even tick = falling edge (shift out next bits).
REQ-013 IDLE->CS_SETUP on accepted start: busy=1, cs_n_out=0 same edge; first bits of cmd driven; one tick later -> CMD.
REQ-014 CMD: 8 SCLK cycles, single line, io_out[0] MSB first, io_oe=4'b0001.
REQ-015 ADDR: 24 cycles single (io_oe=0001) or 6 cycles quad (io_oe=1111, io_out[3] = MSB of nibble), MSB first.
REQ-016 DUMMY: dummy_cyc cycles, io_oe=0000; skipped when dummy_cyc=0.
REQ-017 DATA: 2 quad cycles per byte, high nibble first, data_len bytes; skipped when data_len=0 (ADDR/DUMMY -> CS_HOLD).
REQ-018 DATA write: io_oe=1111; 1-entry holding register; tx_ready=1 in DATA-write while register empty; load on tx_valid&&tx_ready.
REQ-019 Write underflow: if register empty at byte boundary (sclk low), counter frozen, sclk low, cs_n low, until tx_valid; then resume with no lost or duplicated nibble.
REQ-020 DATA read: io_oe=0000; nibble captured from io_in on rising edge; rx_data valid and rx_valid=1 for one cycle, the cycle after the low-nibble rising edge; no backpressure.
REQ-021 Phase transitions SHALL occur on the falling-edge tick of the phase's last cycle; no extra SCLK cycles between phases.
REQ-022 CS_HOLD: one tick with sclk low, cs_n low; then cs_n_out=1, io_oe=0000 -> DONE.
REQ-023 DONE: done=1 one cycle, busy=0 next cycle -> IDLE; start accepted in IDLE on the cycle after done.
REQ-024 tx_ready SHALL be 0 outside DATA-write; tx_valid ignored then.

Reset
REQ-025 h_rstn low SHALL immediately force: state IDLE, sclk_out=0, cs_n_out=1, io_oe=0000, io_out=0000, busy=0, done=0, tx_ready=0, rx_valid=0, rx_data=0, counters 0.
REQ-026 Reset mid-transfer SHALL abort without done; first start after release begins a fresh transfer.

Verification
REQ-027 clk_div=1, cmd=0x9F, addr_quad=0, dummy_cyc=0, data_len=0 -> no ADDR bits skipped: 8+24 SCLK cycles, period 4 h_clk, io_out[0] serial 0x9F then addr MSB-first, done once, cs_n low for CS_SETUP+64 ticks+CS_HOLD.
REQ-028 Quad read: cmd=0xEB, addr=0x123456, addr_quad=1, dummy_cyc=4, data_len=2, io_in model returns 0xA5,0x3C -> 8+6+4+4 cycles, rx_valid twice with 0xA5, 0x3C.
REQ-029 Quad write, data_len=3, tx_valid withheld 20 cycles before byte 2 -> sclk low and frozen during gap, cs_n stays low, io_out nibbles exactly 0x11,0x22,0x33 order.
REQ-030 start asserted while busy, and start pulsed same cycle as done -> ignored; second start one cycle after done -> accepted.
REQ-031 h_rstn asserted mid-ADDR -> outputs per REQ-025 asynchronously, no done; next start completes normally.
REQ-032 clk_div=0 and clk_div=255 with data_len=1 read -> SCLK period 2 and 512 h_clk; correct byte captured.
